spartan6_dsp48a1: RTL and testbench

Parameterised DSP slice modelled on the Xilinx Spartan-6 DSP48A1. It combines an 18-bit pre-adder/subtractor, an 18x18 unsigned multiplier and a 48-bit post-adder/subtractor with carry. Every pipeline stage is individually optional and has its own clock enable and reset. It sits in the datapath as a multiply-accumulate primitive and cascades through BCOUT and PCOUT.

---
 rtl/spartan6_dsp48a1.sv | 274 +++++++++++++++++++++++++++
 tb/tb_spartan6_dsp48a1.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/spartan6_dsp48a1.sv
// spartan6_dsp48a1
//   DSP slice modelled on the Spartan-6 DSP48A1:
//   18-bit pre-adder/subtractor -> 18x18 unsigned multiplier -> 48-bit
//   post-adder/subtractor with carry. Every pipeline stage can be
//   registered (parameter = 1) or bypassed (parameter = 0). Each register
//   group has its own clock enable and asynchronous active-low reset.
//
// Ports
//   CLK                         rising-edge clock
//   RSTA/B/C/D/CARRYIN/M/P/OPMODE  async active-low resets, one per group
//   CEA/B/C/D/CARRYIN/M/P/OPMODE   active-high clock enables, one per group
//   A, B, BCIN, D   [17:0]      multiplier / B / cascade B / pre-adder operands
//   C, PCIN         [47:0]      post-adder operand / cascade post-adder operand
//   CARRYIN                     external carry-in
//   OPMODE          [7:0]       operation select
//   BCOUT           [17:0]      B1-stage output (cascade)
//   M               [35:0]      multiplier output after the M stage
//   P, PCOUT        [47:0]      post-adder result (PCOUT mirrors P)
//   CARRYOUT, CARRYOUTF         post-adder carry/borrow (CARRYOUTF mirrors it)
module spartan6_dsp48a1 #(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTCARRYIN,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CECARRYIN,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [17:0] BCOUT,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  // Pre-adder: om[6] selects subtract; result wraps modulo 2^18.
  function automatic logic [17:0] pre_add(input logic [17:0] d_v,
                                          input logic [17:0] b_v,
                                          input logic        sub);
    pre_add = sub ? (d_v - b_v) : (d_v + b_v);
  endfunction

  // Post-adder at 49 bits. In subtract mode bit 48 is the borrow of
  // Z - (X + cin), i.e. the sign bit of the two's-complement result.
  function automatic logic [48:0] post_add(input logic [47:0] z_v,
                                           input logic [47:0] x_v,
                                           input logic        cin_v,
                                           input logic        sub);
    logic [48:0] xc;
    xc = {1'b0, x_v} + {48'd0, cin_v};
    post_add = sub ? ({1'b0, z_v} - xc) : ({1'b0, z_v} + xc);
  endfunction

  logic [7:0]  om;
  logic [17:0] d, b_src, b0, pre, b1_d, b1, a0, a1;
  logic [47:0] c_r;
  logic [35:0] m_d, m_r;
  logic        cin_src, cin;
  logic [47:0] x_mux, z_mux;
  logic [48:0] sum;
  logic [47:0] p_d, p_r;
  logic        co_d, co_r;

  // ---- input stage: OPMODE, D, C, A0, B0 ----
  generate
    if (OPMODEREG == 1) begin : g_om
      logic [7:0] om_q;
      always_ff @(posedge CLK or negedge RSTOPMODE)
        if (!RSTOPMODE)    om_q <= '0;
        else if (CEOPMODE) om_q <= OPMODE;
      assign om = om_q;
    end else begin : g_om_byp
      assign om = OPMODE;
    end

    if (DREG == 1) begin : g_d
      logic [17:0] d_q;
      always_ff @(posedge CLK or negedge RSTD)
        if (!RSTD)     d_q <= '0;
        else if (CED) d_q <= D;
      assign d = d_q;
    end else begin : g_d_byp
      assign d = D;
    end

    if (CREG == 1) begin : g_c
      logic [47:0] c_q;
      always_ff @(posedge CLK or negedge RSTC)
        if (!RSTC)     c_q <= '0;
        else if (CEC) c_q <= C;
      assign c_r = c_q;
    end else begin : g_c_byp
      assign c_r = C;
    end

    if (A0REG == 1) begin : g_a0
      logic [17:0] a0_q;
      always_ff @(posedge CLK or negedge RSTA)
        if (!RSTA)     a0_q <= '0;
        else if (CEA) a0_q <= A;
      assign a0 = a0_q;
    end else begin : g_a0_byp
      assign a0 = A;
    end
  endgenerate

  // Unknown B_INPUT / CARRYINSEL strings select 0.
  always_comb begin
    b_src = '0;
    if (B_INPUT == "DIRECT")       b_src = B;
    else if (B_INPUT == "CASCADE") b_src = BCIN;
  end

  always_comb begin
    cin_src = 1'b0;
    if (CARRYINSEL == "OPMODE5")      cin_src = om[5];
    else if (CARRYINSEL == "CARRYIN") cin_src = CARRYIN;
  end

  generate
    if (B0REG == 1) begin : g_b0
      logic [17:0] b0_q;
      always_ff @(posedge CLK or negedge RSTB)
        if (!RSTB)     b0_q <= '0;
        else if (CEB) b0_q <= b_src;
      assign b0 = b0_q;
    end else begin : g_b0_byp
      assign b0 = b_src;
    end
  endgenerate

  // ---- pre-adder / A1 / B1 / carry-in stage ----
  assign pre  = pre_add(d, b0, om[6]);
  assign b1_d = om[4] ? pre : b0;

  generate
    if (A1REG == 1) begin : g_a1
      logic [17:0] a1_q;
      always_ff @(posedge CLK or negedge RSTA)
        if (!RSTA)     a1_q <= '0;
        else if (CEA) a1_q <= a0;
      assign a1 = a1_q;
    end else begin : g_a1_byp
      assign a1 = a0;
    end

    if (B1REG == 1) begin : g_b1
      logic [17:0] b1_q;
      always_ff @(posedge CLK or negedge RSTB)
        if (!RSTB)     b1_q <= '0;
        else if (CEB) b1_q <= b1_d;
      assign b1 = b1_q;
    end else begin : g_b1_byp
      assign b1 = b1_d;
    end

    if (CARRYINREG == 1) begin : g_cin
      logic cin_q;
      always_ff @(posedge CLK or negedge RSTCARRYIN)
        if (!RSTCARRYIN)    cin_q <= 1'b0;
        else if (CECARRYIN) cin_q <= cin_src;
      assign cin = cin_q;
    end else begin : g_cin_byp
      assign cin = cin_src;
    end
  endgenerate

  assign BCOUT = b1;

  // ---- multiplier / M stage ----
  assign m_d = a1 * b1;

  generate
    if (MREG == 1) begin : g_m
      logic [35:0] m_q;
      always_ff @(posedge CLK or negedge RSTM)
        if (!RSTM)     m_q <= '0;
        else if (CEM) m_q <= m_d;
      assign m_r = m_q;
    end else begin : g_m_byp
      assign m_r = m_d;
    end
  endgenerate

  assign M = m_r;

  // ---- X/Z muxes, post-adder / P and carry-out stage ----
  always_comb begin
    x_mux = '0;
    case (om[1:0])
      2'd0: x_mux = '0;
      2'd1: x_mux = {12'd0, m_r};
      2'd2: x_mux = p_r;
      2'd3: x_mux = {d[11:0], a1, b1};
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (om[3:2])
      2'd0: z_mux = '0;
      2'd1: z_mux = PCIN;
      2'd2: z_mux = p_r;
      2'd3: z_mux = c_r;
      default: z_mux = '0;
    endcase
  end

  assign sum  = post_add(z_mux, x_mux, cin, om[7]);
  assign p_d  = sum[47:0];
  assign co_d = sum[48];

  generate
    if (PREG == 1) begin : g_p
      logic [47:0] p_q;
      always_ff @(posedge CLK or negedge RSTP)
        if (!RSTP)     p_q <= '0;
        else if (CEP) p_q <= p_d;
      assign p_r = p_q;
    end else begin : g_p_byp
      assign p_r = p_d;
    end

    // Carry-out shares the carry-in group's enable and reset.
    if (CARRYOUTREG == 1) begin : g_co
      logic co_q;
      always_ff @(posedge CLK or negedge RSTCARRYIN)
        if (!RSTCARRYIN)    co_q <= 1'b0;
        else if (CECARRYIN) co_q <= co_d;
      assign co_r = co_q;
    end else begin : g_co_byp
      assign co_r = co_d;
    end
  endgenerate

  assign P         = p_r;
  assign PCOUT     = p_r;
  assign CARRYOUT  = co_r;
  assign CARRYOUTF = co_r;

endmodule

// File: tb/tb_spartan6_dsp48a1.sv
module tb_spartan6_dsp48a1;

  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTCARRYIN, RSTM, RSTP, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CECARRYIN, CEM, CEP, CEOPMODE;
  logic [17:0] A, B, BCIN, D;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int errors = 0;
  int checks = 0;

  spartan6_dsp48a1 dut (
    .CLK(CLK),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
    .RSTCARRYIN(RSTCARRYIN), .RSTM(RSTM), .RSTP(RSTP), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
    .CECARRYIN(CECARRYIN), .CEM(CEM), .CEP(CEP), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 CLK = ~CLK;

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_rst(input logic v);
    RSTA = v; RSTB = v; RSTC = v; RSTD = v;
    RSTCARRYIN = v; RSTM = v; RSTP = v; RSTOPMODE = v;
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEC = v; CED = v;
    CECARRYIN = v; CEM = v; CEP = v; CEOPMODE = v;
  endtask

  task automatic test_reset();
    set_rst(1'b0);
    set_ce(1'b1);
    A = 18'd7; B = 18'd9; BCIN = 18'd3; D = 18'd11;
    C = 48'd13; PCIN = 48'd17; CARRYIN = 1'b1; OPMODE = 8'h3D;
    edges(1);
    checks++; if (BCOUT !== 18'd0) begin errors++; $display("FAIL reset_bcout got=%0d exp=0", BCOUT); end
    checks++; if (M !== 36'd0) begin errors++; $display("FAIL reset_m got=%0d exp=0", M); end
    checks++; if (P !== 48'd0) begin errors++; $display("FAIL reset_p got=%0d exp=0", P); end
    checks++; if (PCOUT !== 48'd0) begin errors++; $display("FAIL reset_pcout got=%0d exp=0", PCOUT); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL reset_co got=%0b exp=0", CARRYOUT); end
    checks++; if (CARRYOUTF !== 1'b0) begin errors++; $display("FAIL reset_cof got=%0b exp=0", CARRYOUTF); end
    set_rst(1'b1);
  endtask

  // OPMODE 0x3D: X=M, Z=C, pre-adder add, carry-in = om[5] = 1.
  // (40+20)=60, 10*60=600, 30+600+1=631.
  task automatic test_preadder_mac();
    A = 18'd10; B = 18'd20; C = 48'd30; D = 18'd40; OPMODE = 8'h3D;
    edges(4);
    checks++; if (BCOUT !== 18'd60) begin errors++; $display("FAIL mac1_bcout got=%0d exp=60", BCOUT); end
    checks++; if (M !== 36'd600) begin errors++; $display("FAIL mac1_m got=%0d exp=600", M); end
    checks++; if (P !== 48'd631) begin errors++; $display("FAIL mac1_p got=%0d exp=631", P); end
    checks++; if (PCOUT !== 48'd631) begin errors++; $display("FAIL mac1_pcout got=%0d exp=631", PCOUT); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL mac1_co got=%0b exp=0", CARRYOUT); end
    checks++; if (CARRYOUTF !== 1'b0) begin errors++; $display("FAIL mac1_cof got=%0b exp=0", CARRYOUTF); end
  endtask

  // OPMODE 0x1D: same as above with carry-in 0. (5+5)=10, 100, 50+100=150.
  task automatic test_preadder_mac2();
    A = 18'd10; B = 18'd5; C = 48'd50; D = 18'd5; OPMODE = 8'h1D;
    edges(4);
    checks++; if (BCOUT !== 18'd10) begin errors++; $display("FAIL mac2_bcout got=%0d exp=10", BCOUT); end
    checks++; if (M !== 36'd100) begin errors++; $display("FAIL mac2_m got=%0d exp=100", M); end
    checks++; if (P !== 48'd150) begin errors++; $display("FAIL mac2_p got=%0d exp=150", P); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL mac2_co got=%0b exp=0", CARRYOUT); end
  endtask

  // OPMODE 0x01: X=M, Z=0, B bypasses the pre-adder.
  task automatic test_mult_only();
    A = 18'd10; B = 18'd5; OPMODE = 8'h01;
    edges(4);
    checks++; if (BCOUT !== 18'd5) begin errors++; $display("FAIL mult_bcout got=%0d exp=5", BCOUT); end
    checks++; if (M !== 36'd50) begin errors++; $display("FAIL mult_m got=%0d exp=50", M); end
    checks++; if (P !== 48'd50) begin errors++; $display("FAIL mult_p got=%0d exp=50", P); end
    checks++; if (PCOUT !== 48'd50) begin errors++; $display("FAIL mult_pcout got=%0d exp=50", PCOUT); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL mult_co got=%0b exp=0", CARRYOUT); end
  endtask

  // OPMODE 0x8D: P = C - M. 100-6 = 94 no borrow; 0-6 wraps with borrow.
  task automatic test_subtract();
    A = 18'd2; B = 18'd3; C = 48'd100; OPMODE = 8'h8D;
    edges(4);
    checks++; if (P !== 48'd94) begin errors++; $display("FAIL sub_p got=%0d exp=94", P); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL sub_co got=%0b exp=0", CARRYOUT); end
    C = 48'd0;
    edges(4);
    checks++; if (P !== 48'hFFFF_FFFF_FFFA) begin errors++; $display("FAIL borrow_p got=%0h exp=fffffffffffa", P); end
    checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("FAIL borrow_co got=%0b exp=1", CARRYOUT); end
    checks++; if (CARRYOUTF !== 1'b1) begin errors++; $display("FAIL borrow_cof got=%0b exp=1", CARRYOUTF); end
  endtask

  // P holds under CEP=0; carry-out holds under its own enable (CECARRYIN).
  // Then RSTP clears P asynchronously, leaving carry-out alone.
  task automatic test_ce_hold();
    CEP = 1'b0; CECARRYIN = 1'b0;
    A = 18'd1; B = 18'd1; C = 48'd50;
    edges(4);
    checks++; if (P !== 48'hFFFF_FFFF_FFFA) begin errors++; $display("FAIL hold_p got=%0h exp=fffffffffffa", P); end
    checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("FAIL hold_co got=%0b exp=1", CARRYOUT); end
    RSTP = 1'b0;
    #1;
    checks++; if (P !== 48'd0) begin errors++; $display("FAIL rstp_async_p got=%0h exp=0", P); end
    checks++; if (PCOUT !== 48'd0) begin errors++; $display("FAIL rstp_async_pcout got=%0h exp=0", PCOUT); end
    checks++; if (CARRYOUT !== 1'b1) begin errors++; $display("FAIL rstp_keeps_co got=%0b exp=1", CARRYOUT); end
    RSTP = 1'b1;
    set_ce(1'b1);
  endtask

  // OPMODE 0x09: X=M (=6), Z=P. After clearing P, three edges give 18.
  task automatic test_accumulate();
    A = 18'd2; B = 18'd3; C = 48'd0; OPMODE = 8'h09;
    edges(4);
    RSTP = 1'b0;
    #1;
    RSTP = 1'b1;
    edges(3);
    checks++; if (P !== 48'd18) begin errors++; $display("FAIL accum_p got=%0d exp=18", P); end
    checks++; if (CARRYOUT !== 1'b0) begin errors++; $display("FAIL accum_co got=%0b exp=0", CARRYOUT); end
  endtask

  initial begin
    test_reset();
    test_preadder_mac();
    test_preadder_mac2();
    test_mult_only();
    test_subtract();
    test_ce_hold();
    test_accumulate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
